// File: rtl/slt_serial_comparator_if.sv
// rtl/slt_serial_comparator_if.sv - start/busy/done handshake and operand bundle for the serial comparator
interface slt_serial_comparator_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             less_than;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, less_than
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, less_than
    );
endinterface

// File: rtl/slt_serial_comparator.sv
// rtl/slt_serial_comparator.sv - multi-cycle a<b compare (slt/sltu), STEP bits of a+~b+1 per cycle
module slt_serial_comparator #(
    parameter int WIDTH = 32,
    parameter int STEP  = 8
) (
    input logic                    clk,
    input logic                    rst_n,
    slt_serial_comparator_if.slave bus
);
    localparam int N  = WIDTH / STEP;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             mode_q, mode_d;
    logic             carry_q, carry_d;
    logic             done_q, done_d;
    logic             lt_q, lt_d;
    logic [IW-1:0]    idx_q, idx_d;

    logic [STEP-1:0]  a_slice;
    logic [STEP-1:0]  nb_slice;
    logic [STEP:0]    sum;
    logic             cout;
    logic             cmsb;
    logic             dmsb;
    logic             last;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] b_next;

    // Operands shift right so the active slice is always the low STEP bits.
    assign a_slice  = a_q[STEP-1:0];
    assign nb_slice = ~b_q[STEP-1:0];
    assign sum      = {1'b0, a_slice} + {1'b0, nb_slice} + {{STEP{1'b0}}, carry_q};
    assign cout     = sum[STEP];
    assign dmsb     = sum[STEP-1];
    assign cmsb     = sum[STEP-1] ^ a_slice[STEP-1] ^ nb_slice[STEP-1];
    assign last     = (idx_q == IW'(N - 1));

    if (N > 1) begin : g_shift
        assign a_next = {{STEP{1'b0}}, a_q[WIDTH-1:STEP]};
        assign b_next = {{STEP{1'b0}}, b_q[WIDTH-1:STEP]};
    end else begin : g_noshift
        assign a_next = a_q;
        assign b_next = b_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            lt_q    <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            carry_q <= carry_d;
            done_q  <= done_d;
            lt_q    <= lt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        carry_d = carry_q;
        done_d  = 1'b0;
        lt_d    = lt_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    mode_d  = bus.signed_mode;
                    carry_d = 1'b1;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                carry_d = cout;
                idx_d   = idx_q + 1'b1;
                a_d     = a_next;
                b_d     = b_next;
                if (last) begin
                    // Signed: sign of difference corrected by overflow; unsigned: borrow.
                    lt_d    = mode_q ? (dmsb ^ cmsb ^ cout) : ~cout;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy      = (state_q == RUN);
    assign bus.done      = done_q;
    assign bus.less_than = lt_q;
endmodule
